// File: rtl/seg_scan_driver_pkg.sv
// Shared constants and helpers for the six-tube multiplexed display scanner.
// Segment bit order, digit count, default timing and slot decode functions.
package seg_scan_driver_pkg;

   localparam int unsigned SEG_A  = 7;
   localparam int unsigned SEG_B  = 6;
   localparam int unsigned SEG_C  = 5;
   localparam int unsigned SEG_D  = 4;
   localparam int unsigned SEG_E  = 3;
   localparam int unsigned SEG_F  = 2;
   localparam int unsigned SEG_G  = 1;
   localparam int unsigned SEG_DP = 0;

   localparam int unsigned NUM_DIGITS      = 6;
   localparam int unsigned DEF_ON_STEP     = 24500;
   localparam int unsigned DEF_BLANK_TICKS = 2000;

   typedef logic [2:0] slot_t;

   localparam slot_t LAST_SLOT = 3'(NUM_DIGITS - 1);

   // Slot 0 drives the leftmost tube (bit 7); bits 1:0 are never used.
   function automatic logic [7:0] slot_to_tub(input slot_t slot);
      logic [7:0] tub;
      case (slot)
         3'd0:    tub = 8'h80;
         3'd1:    tub = 8'h40;
         3'd2:    tub = 8'h20;
         3'd3:    tub = 8'h10;
         3'd4:    tub = 8'h08;
         3'd5:    tub = 8'h04;
         default: tub = 8'h00;
      endcase
      return tub;
   endfunction

   function automatic logic [7:0] slot_pattern(input slot_t slot, input logic [47:0] pats);
      logic [7:0] pat;
      case (slot)
         3'd0:    pat = pats[7:0];
         3'd1:    pat = pats[15:8];
         3'd2:    pat = pats[23:16];
         3'd3:    pat = pats[31:24];
         3'd4:    pat = pats[39:32];
         3'd5:    pat = pats[47:40];
         default: pat = 8'h00;
      endcase
      return pat;
   endfunction

endpackage

// File: rtl/seg_scan_driver.sv
// Time-multiplexed six-tube display scanner with per-frame snapshot,
// brightness-controlled lit window and a guaranteed dark guard per slot.
module seg_scan_driver
   import seg_scan_driver_pkg::*;
#(
   parameter int unsigned ON_STEP     = DEF_ON_STEP,
   parameter int unsigned BLANK_TICKS = DEF_BLANK_TICKS
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       power_state,
   input  logic [1:0] brightness,
   input  logic [7:0] hour_tub_control_1,
   input  logic [7:0] hour_tub_control_2,
   input  logic [7:0] minute_tub_control_1,
   input  logic [7:0] minute_tub_control_2,
   input  logic [7:0] second_tub_control_1,
   input  logic [7:0] second_tub_control_2,
   output logic [7:0] tub_sel,
   output logic [7:0] seg_out,
   output logic       frame_done
);

   localparam int unsigned DIGIT_TICKS = 4 * ON_STEP + BLANK_TICKS;
   localparam int unsigned TW          = $clog2(DIGIT_TICKS);
   localparam logic [TW-1:0] TICK_LAST = TW'(DIGIT_TICKS - 1);

   logic [TW-1:0] tick_q, tick_d;
   slot_t         slot_q, slot_d;
   logic [47:0]   pats_q, pats_d;
   logic [1:0]    bright_q, bright_d;
   logic [7:0]    tub_sel_q, tub_sel_d;
   logic [7:0]    seg_out_q, seg_out_d;
   logic          frame_done_q, frame_done_d;

   logic [47:0]   live_pats_s;
   logic [47:0]   view_pats_s;
   logic [1:0]    view_bright_s;
   logic          frame_start_s;
   logic [31:0]   lit_limit_s;

   assign live_pats_s = {second_tub_control_2, second_tub_control_1,
                         minute_tub_control_2, minute_tub_control_1,
                         hour_tub_control_2,   hour_tub_control_1};

   // Counters, snapshot and next output values; the first slot of a frame
   // uses the live inputs directly since that is what gets captured.
   always_comb begin
      tick_d        = tick_q;
      slot_d        = slot_q;
      pats_d        = pats_q;
      bright_d      = bright_q;
      tub_sel_d     = 8'h00;
      seg_out_d     = 8'h00;
      frame_done_d  = 1'b0;

      frame_start_s = (slot_q == 3'd0) && (tick_q == {TW{1'b0}});
      if (frame_start_s) begin
         view_pats_s   = live_pats_s;
         view_bright_s = brightness;
      end else begin
         view_pats_s   = pats_q;
         view_bright_s = bright_q;
      end
      lit_limit_s = (32'(view_bright_s) + 32'd1) * ON_STEP;

      if (!power_state) begin
         tick_d = {TW{1'b0}};
         slot_d = 3'd0;
      end else begin
         if (frame_start_s) begin
            pats_d   = live_pats_s;
            bright_d = brightness;
         end else begin
            pats_d   = pats_q;
            bright_d = bright_q;
         end

         if (tick_q == TICK_LAST) begin
            tick_d = {TW{1'b0}};
            if (slot_q == LAST_SLOT) begin
               slot_d       = 3'd0;
               frame_done_d = 1'b1;
            end else begin
               slot_d = slot_q + 3'd1;
            end
         end else begin
            tick_d = tick_q + TW'(1);
         end

         if (32'(tick_q) < lit_limit_s) begin
            tub_sel_d = slot_to_tub(slot_q);
            seg_out_d = slot_pattern(slot_q, view_pats_s);
         end else begin
            tub_sel_d = 8'h00;
            seg_out_d = 8'h00;
         end
      end
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         tick_q       <= {TW{1'b0}};
         slot_q       <= 3'd0;
         pats_q       <= 48'h0;
         bright_q     <= 2'd0;
         tub_sel_q    <= 8'h00;
         seg_out_q    <= 8'h00;
         frame_done_q <= 1'b0;
      end else begin
         tick_q       <= tick_d;
         slot_q       <= slot_d;
         pats_q       <= pats_d;
         bright_q     <= bright_d;
         tub_sel_q    <= tub_sel_d;
         seg_out_q    <= seg_out_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign tub_sel    = tub_sel_q;
   assign seg_out    = seg_out_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver with ON_STEP=2, BLANK_TICKS=2.
// Per-cycle expectations flow through a scoreboard queue.
module tb_seg_scan_driver;

   localparam int DT = 10;

   logic       clk = 1'b0;
   logic       reset;
   logic       power_state;
   logic [1:0] brightness;
   logic [7:0] h1, h2, m1, m2, s1, s2;
   logic [7:0] tub_sel;
   logic [7:0] seg_out;
   logic       frame_done;

   int total = 0;
   int bad   = 0;
   bit mon_en = 1'b0;

   typedef struct {
      logic [7:0] tub;
      logic [7:0] seg;
      logic       fd;
      string      name;
   } exp_t;

   typedef struct {
      logic       power;
      logic [1:0] bright;
      logic [7:0] tub;
      logic [7:0] seg;
      logic       fd;
      int         n;
      string      name;
   } vec_t;

   exp_t sb[$];
   vec_t vecs[$];

   seg_scan_driver #(.ON_STEP(2), .BLANK_TICKS(2)) dut (
      .clk                  (clk),
      .reset                (reset),
      .power_state          (power_state),
      .brightness           (brightness),
      .hour_tub_control_1   (h1),
      .hour_tub_control_2   (h2),
      .minute_tub_control_1 (m1),
      .minute_tub_control_2 (m2),
      .second_tub_control_1 (s1),
      .second_tub_control_2 (s2),
      .tub_sel              (tub_sel),
      .seg_out              (seg_out),
      .frame_done           (frame_done)
   );

   always #5 clk = ~clk;

   // Structural invariant on the outputs every cycle.
   always @(negedge clk) begin
      if (mon_en) begin
         total++;
         if (!$onehot0(tub_sel) || (tub_sel[1:0] != 2'b00) ||
             ((tub_sel == 8'h00) && (seg_out != 8'h00))) begin
            bad++;
            $display("FAIL onehot0: tub=%h seg=%h, want one-hot-or-zero tub, seg=0 when tub=0",
                     tub_sel, seg_out);
         end
      end
   end

   task automatic check_one();
      exp_t e;
      e = sb.pop_front();
      total++;
      if ((tub_sel !== e.tub) || (seg_out !== e.seg) || (frame_done !== e.fd)) begin
         bad++;
         $display("FAIL %s: got tub=%h seg=%h fd=%b, want tub=%h seg=%h fd=%b",
                  e.name, tub_sel, seg_out, frame_done, e.tub, e.seg, e.fd);
      end
   endtask

   task automatic run(input logic [7:0] tub, input logic [7:0] seg, input logic fd,
                      input int n, input string name);
      for (int i = 0; i < n; i++) begin
         exp_t e;
         e.tub = tub; e.seg = seg; e.fd = fd; e.name = name;
         sb.push_back(e);
         @(posedge clk);
         @(negedge clk);
         check_one();
      end
   endtask

   task automatic run_slot(input int s, input int lit, input logic [7:0] seg,
                           input bit last, input string name);
      logic [7:0] tub;
      tub = 8'(8'h80 >> s);
      run(tub, seg, 1'b0, lit, name);
      if (last) begin
         run(8'h00, 8'h00, 1'b0, DT - lit - 1, {name, "_dark"});
         run(8'h00, 8'h00, 1'b1, 1, {name, "_fd"});
      end else begin
         run(8'h00, 8'h00, 1'b0, DT - lit, {name, "_dark"});
      end
   endtask

   task automatic add_row(input logic p, input logic [1:0] b, input logic [7:0] tub,
                          input logic [7:0] seg, input logic fd, input int n, input string name);
      vec_t v;
      v.power = p; v.bright = b; v.tub = tub; v.seg = seg; v.fd = fd; v.n = n; v.name = name;
      vecs.push_back(v);
   endtask

   initial begin
      int lit;
      logic [1:0] b_in;

      // Frame 1 at brightness 3 (8 lit); brightness drops to 0 from slot 3
      // but must only apply in frame 2 (2 lit).
      for (int f = 0; f < 2; f++) begin
         for (int s = 0; s < 6; s++) begin
            lit  = (f == 0) ? 8 : 2;
            b_in = ((f == 0) && (s < 3)) ? 2'd3 : 2'd0;
            add_row(1'b1, b_in, 8'(8'h80 >> s), 8'(s + 1), 1'b0, lit,
                    $sformatf("f%0d_s%0d_lit", f + 1, s));
            if (s == 5) begin
               add_row(1'b1, 2'd0, 8'h00, 8'h00, 1'b0, DT - lit - 1,
                       $sformatf("f%0d_s5_dark", f + 1));
               add_row(1'b1, 2'd0, 8'h00, 8'h00, 1'b1, 1, $sformatf("f%0d_fd", f + 1));
            end else begin
               add_row(1'b1, b_in, 8'h00, 8'h00, 1'b0, DT - lit,
                       $sformatf("f%0d_s%0d_dark", f + 1, s));
            end
         end
      end

      reset = 1'b0; power_state = 1'b1; brightness = 2'd3;
      h1 = 8'h01; h2 = 8'h02; m1 = 8'h03; m2 = 8'h04; s1 = 8'h05; s2 = 8'h06;
      @(negedge clk);
      run(8'h00, 8'h00, 1'b0, 3, "reset_state");
      mon_en = 1'b1;
      reset = 1'b1; power_state = 1'b0;
      run(8'h00, 8'h00, 1'b0, 2, "idle_off");

      foreach (vecs[i]) begin
         power_state = vecs[i].power;
         brightness  = vecs[i].bright;
         run(vecs[i].tub, vecs[i].seg, vecs[i].fd, vecs[i].n, vecs[i].name);
      end

      // Frame 3: minute_1 changed during slot 1 must not tear slot 2.
      brightness = 2'd3; m1 = 8'hFC;
      run_slot(0, 8, 8'h01, 1'b0, "f3_s0");
      run(8'h40, 8'h02, 1'b0, 3, "f3_s1a");
      m1 = 8'h60;
      run(8'h40, 8'h02, 1'b0, 5, "f3_s1b");
      run(8'h00, 8'h00, 1'b0, 2, "f3_s1_dark");
      run_slot(2, 8, 8'hFC, 1'b0, "f3_s2_old");
      run_slot(3, 8, 8'h04, 1'b0, "f3_s3");
      run_slot(4, 8, 8'h05, 1'b0, "f3_s4");
      run_slot(5, 8, 8'h06, 1'b1, "f3_s5");

      // Frame 4 shows the new pattern, then power drops in slot 3.
      run_slot(0, 8, 8'h01, 1'b0, "f4_s0");
      run_slot(1, 8, 8'h02, 1'b0, "f4_s1");
      run_slot(2, 8, 8'h60, 1'b0, "f4_s2_new");
      run(8'h10, 8'h04, 1'b0, 3, "f4_s3_partial");
      power_state = 1'b0; brightness = 2'd1;
      run(8'h00, 8'h00, 1'b0, 70, "power_off");

      // Restart with a fresh snapshot (brightness 1 -> 4 lit cycles).
      power_state = 1'b1;
      run(8'h80, 8'h01, 1'b0, 1, "repower_first");
      run(8'h80, 8'h01, 1'b0, 3, "repower_s0");
      run(8'h00, 8'h00, 1'b0, 6, "repower_s0_dark");
      run_slot(1, 4, 8'h02, 1'b0, "f5_s1");
      run_slot(2, 4, 8'h60, 1'b0, "f5_s2");
      run_slot(3, 4, 8'h04, 1'b0, "f5_s3");
      run(8'h08, 8'h05, 1'b0, 3, "f5_s4_partial");
      reset = 1'b0;
      run(8'h00, 8'h00, 1'b0, 1, "mid_reset");
      reset = 1'b1;
      run_slot(0, 4, 8'h01, 1'b0, "post_reset_s0");
      run_slot(1, 4, 8'h02, 1'b0, "post_reset_s1");
      run_slot(2, 4, 8'h60, 1'b0, "post_reset_s2");
      run_slot(3, 4, 8'h04, 1'b0, "post_reset_s3");
      run_slot(4, 4, 8'h05, 1'b0, "post_reset_s4");
      run_slot(5, 4, 8'h06, 1'b1, "post_reset_s5");
      run_slot(0, 4, 8'h01, 1'b0, "post_reset_next");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
